alu_operand_stage: RTL
======================

# alu_operand_stage

Parametrised operand-selection stage at the decode/execute boundary. It resolves register forwarding itself by comparing source register numbers against a configurable number of in-flight producers, with the youngest producer taking priority. It detects load-use interlocks and selects the ALU A/B operands and store data. The selected operands are registered into the execute pipeline register under a valid/ready handshake with flush support.

## Interface
Parameters:
- DATA_W, 32, operand/data width
- REG_AW, 5, register-number width
- NUM_FWD, 3, number of forwarding sources; index 0 is youngest (highest priority)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- in_valid  in  1  decode-side operands present
- in_ready  out  1  stage accepts this cycle
- rs_addr, rt_addr  in  REG_AW  source register numbers
- rs_data, rt_data  in  DATA_W  register-file read data
- sa  in  5  shift amount
- sign_imm  in  DATA_W  sign-extended immediate
- pc_plus_eight  in  DATA_W  link value
- src_a_sel  in  1  0: forwarded rs; 1: zero-extended sa
- src_b_sel  in  2  00: forwarded rt; 01: sign_imm; 10: pc_plus_eight; 11: zero
- fwd_valid  in  NUM_FWD  source i writes a register
- fwd_pending  in  NUM_FWD  source i result not yet available (load in flight)
- fwd_waddr  in  NUM_FWD*REG_AW  destination register of source i (packed, i at LSBs)
- fwd_data  in  NUM_FWD*DATA_W  result of source i (packed)
- flush  in  1  discard the registered and incoming operation
- out_valid  out  1  execute register holds an operation
- out_ready  in  1  execute stage consumes
- src_a, src_b, write_data  out  DATA_W  registered ALU operands and store data
- interlock  out  1  combinational: in_valid and a pending hazard exists

## Operation
- Per operand (rs, rt): scan i = 0..NUM_FWD-1. The first i with fwd_valid[i], fwd_waddr[i]==addr and addr!=0 wins and supplies fwd_data[i]. With no match, the register-file value is used. Address 0 is never forwarded.
- Hazard: a winning source has fwd_pending set. Older matching sources are ignored even if they are not pending. A hazard on rt counts only when src_b_sel==00 or when write_data is used; write_data is always used, so rt is always checked. A hazard on rs counts only when src_a_sel==0.
- in_ready = !hazard && !flush && (!out_valid || out_ready).
- Capture occurs when in_valid && in_ready. Outputs are loaded with the selected values: src_a by src_a_sel, src_b by src_b_sel, write_data = forwarded rt.
- out_valid next state:
  - flush: 0
  - capture: 1
  - out_ready: 0
  - otherwise: hold
- Outputs are held stable while out_valid && !out_ready.
- Hazard behaviour: in_ready=0 and interlock=1. The register drains normally, so an earlier operation still leaves.
- Simultaneous events:
  - flush with in_valid: input is dropped and out_valid=0 next cycle.
  - flush with out_ready: the held operation is dropped. No consumption is signalled beyond out_ready itself.
- Reset (asynchronous, any cycle including mid-hold): out_valid=0; src_a, src_b and write_data = 0; counter = 0.

## Timing
- Latency 1 cycle from capture to out_valid.
- Throughput 1 operation/cycle when out_ready is held high and there are no hazards.
- in_ready, interlock and forwarding selection are combinational from the inputs and out_valid. No combinational path exists from out_ready to any data output.
- A pending source that clears in cycle n allows capture in cycle n. The forwarded data is sampled in the same cycle.

## Configuration
- OPSTAGE_STALL_CNT_EN
  - Defined: adds output stall_count (16 bits). It increments on every cycle with interlock=1, saturates at 0xFFFF, and is cleared only by reset.
  - Undefined: the port and counter are absent and behaviour is otherwise identical.

## Structure
- Package alu_operand_pkg holds:
  - enum src_a_sel_e (SRC_A_REG, SRC_A_SA)
  - enum src_b_sel_e (SRC_B_REG, SRC_B_IMM, SRC_B_LINK, SRC_B_ZERO)
  - constant REG_ZERO
- Sub-module fwd_select is instantiated twice (rs, rt). It is combinational, takes the NUM_FWD compare inputs, and returns the selected data plus a hazard flag.

## Test plan
- rs_addr=5, fwd 0 and 1 both write r5 (data 0x11, 0x22), none pending, src_a_sel=0 → src_a=0x11 one cycle after capture.
- rt_addr=0, fwd 0 writes r0 with 0xFFFF, rt_data=0 → write_data=0, no interlock.
- rs_addr=3, fwd 0 writes r3 with fwd_pending=1 for 2 cycles → interlock=1 and in_ready=0 for 2 cycles. Capture occurs on the 3rd cycle with fwd_data[0].
- src_b_sel=10, pc_plus_eight=0x400008, out_ready=0 for 3 cycles → src_b=0x400008 held stable with out_valid=1, and in_ready=0 throughout.
- flush asserted with in_valid=1 and out_valid=1 → out_valid=0 next cycle. Reset asserted mid-hold → outputs 0 immediately without waiting for a clock edge.
- OPSTAGE_STALL_CNT_EN defined, 5 interlock cycles → stall_count=5. Forcing 0x10000 interlock cycles → stall_count=0xFFFF.

Source files
------------

// File: rtl/alu_operand_pkg.sv
// ---------------------------------------------------------------------------
// alu_operand_pkg
// Shared definitions for the ALU operand-selection stage:
//   src_a_sel_e : encoding of the ALU A-operand select input
//   src_b_sel_e : encoding of the ALU B-operand select input
//   REG_ZERO    : the hard-wired zero register, which is never forwarded
// ---------------------------------------------------------------------------
package alu_operand_pkg;

    typedef enum logic {
        SRC_A_REG = 1'b0,
        SRC_A_SA  = 1'b1
    } src_a_sel_e;

    typedef enum logic [1:0] {
        SRC_B_REG  = 2'b00,
        SRC_B_IMM  = 2'b01,
        SRC_B_LINK = 2'b10,
        SRC_B_ZERO = 2'b11
    } src_b_sel_e;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
// Combinational forwarding resolver for one source operand.
// Ports:
//   addr        in  source register number
//   reg_data    in  register-file read value (used when nothing matches)
//   fwd_valid   in  per-source "writes a register" flags
//   fwd_pending in  per-source "result not yet available" flags
//   fwd_waddr   in  packed destination registers, source 0 at LSBs
//   fwd_data    in  packed results, source 0 at LSBs
//   data        out resolved operand value
//   hazard      out the winning source is still pending
// Source 0 is the youngest producer and has the highest priority.
// ---------------------------------------------------------------------------
module fwd_select
    import alu_operand_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 3
) (
    input  logic [REG_AW-1:0]         addr,
    input  logic [DATA_W-1:0]         reg_data,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    output logic [DATA_W-1:0]         data,
    output logic                      hazard
);

    logic [NUM_FWD-1:0] match;

    // Per-source address match; register zero never matches.
    for (genvar g = 0; g < NUM_FWD; g++) begin : g_match
        assign match[g] = fwd_valid[g]
                          && (fwd_waddr[g*REG_AW +: REG_AW] == addr)
                          && (addr != REG_AW'(REG_ZERO));
    end

    // Priority select: scan oldest to youngest so the youngest match lands last
    // and wins; only the winner's pending flag matters.
    always_comb begin
        data   = reg_data;
        hazard = 1'b0;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            data   = match[i] ? fwd_data[i*DATA_W +: DATA_W] : data;
            hazard = match[i] ? fwd_pending[i] : hazard;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
// Operand-selection stage between decode and execute. Resolves forwarding for
// rs/rt, detects load-use interlocks, selects ALU A/B operands and store data,
// and registers them into the execute pipeline register under valid/ready
// with flush.
// Ports:
//   clk, reset (async, active-high)
//   in_valid/in_ready             decode-side handshake
//   rs_addr, rt_addr, rs_data, rt_data, sa, sign_imm, pc_plus_eight
//   src_a_sel, src_b_sel          operand selects
//   fwd_valid, fwd_pending, fwd_waddr, fwd_data   in-flight producers
//   flush                         drop registered and incoming operation
//   out_valid/out_ready           execute-side handshake
//   src_a, src_b, write_data      registered operands
//   interlock                     combinational load-use stall indication
//   stall_count                   only with OPSTAGE_STALL_CNT_EN defined:
//                                 saturating count of interlock cycles
// ---------------------------------------------------------------------------
module alu_operand_stage
    import alu_operand_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [REG_AW-1:0]         rs_addr,
    input  logic [REG_AW-1:0]         rt_addr,
    input  logic [DATA_W-1:0]         rs_data,
    input  logic [DATA_W-1:0]         rt_data,
    input  logic [4:0]                sa,
    input  logic [DATA_W-1:0]         sign_imm,
    input  logic [DATA_W-1:0]         pc_plus_eight,
    input  logic                      src_a_sel,
    input  logic [1:0]                src_b_sel,
    input  logic [NUM_FWD-1:0]        fwd_valid,
    input  logic [NUM_FWD-1:0]        fwd_pending,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         src_a,
    output logic [DATA_W-1:0]         src_b,
    output logic [DATA_W-1:0]         write_data,
    output logic                      interlock
`ifdef OPSTAGE_STALL_CNT_EN
    ,
    output logic [15:0]               stall_count
`endif
);

    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;
    logic              rs_hazard;
    logic              rt_hazard;
    logic              hazard;
    logic              capture;
    logic              out_valid_next;
    logic [DATA_W-1:0] src_a_next;
    logic [DATA_W-1:0] src_b_next;

    fwd_select #(
        .DATA_W  (DATA_W),
        .REG_AW  (REG_AW),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_rs (
        .addr        (rs_addr),
        .reg_data    (rs_data),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_waddr   (fwd_waddr),
        .fwd_data    (fwd_data),
        .data        (rs_fwd),
        .hazard      (rs_hazard)
    );

    fwd_select #(
        .DATA_W  (DATA_W),
        .REG_AW  (REG_AW),
        .NUM_FWD (NUM_FWD)
    ) u_fwd_rt (
        .addr        (rt_addr),
        .reg_data    (rt_data),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_waddr   (fwd_waddr),
        .fwd_data    (fwd_data),
        .data        (rt_fwd),
        .hazard      (rt_hazard)
    );

    // rt always feeds write_data, so its hazard always counts; rs only when
    // the A operand actually reads the register.
    assign hazard    = (rs_hazard && (src_a_sel == SRC_A_REG)) || rt_hazard;
    assign interlock = in_valid && hazard;
    assign in_ready  = !hazard && !flush && (!out_valid || out_ready);
    assign capture   = in_valid && in_ready;

    // Operand muxes feeding the execute register.
    always_comb begin
        src_a_next = rs_fwd;
        src_b_next = rt_fwd;
        case (src_a_sel)
            SRC_A_REG: src_a_next = rs_fwd;
            SRC_A_SA:  src_a_next = {{(DATA_W-5){1'b0}}, sa};
            default:   src_a_next = rs_fwd;
        endcase
        case (src_b_sel)
            SRC_B_REG:  src_b_next = rt_fwd;
            SRC_B_IMM:  src_b_next = sign_imm;
            SRC_B_LINK: src_b_next = pc_plus_eight;
            SRC_B_ZERO: src_b_next = {DATA_W{1'b0}};
            default:    src_b_next = rt_fwd;
        endcase
    end

    // Execute-register occupancy: flush dominates, then a new capture.
    always_comb begin
        out_valid_next = out_valid;
        if (flush) begin
            out_valid_next = 1'b0;
        end else if (capture) begin
            out_valid_next = 1'b1;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end else begin
            out_valid_next = out_valid;
        end
    end

    // Occupancy flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid_next;
        end
    end

    // Operand registers load only on capture, so they hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_a      <= {DATA_W{1'b0}};
            src_b      <= {DATA_W{1'b0}};
            write_data <= {DATA_W{1'b0}};
        end else if (capture) begin
            src_a      <= src_a_next;
            src_b      <= src_b_next;
            write_data <= rt_fwd;
        end
    end

`ifdef OPSTAGE_STALL_CNT_EN
    // Saturating interlock-cycle counter; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (interlock && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end
`endif

endmodule
